mips_cpu_bus_arbiter: RTL and testbench

Shares the single Avalon memory-mapped master port of mips_cpu_bus between two internal requesters: the instruction-fetch port and the load/store data port. It holds every transfer across waitrequest stalls and round-robins between the ports when both request together. It registers read data, returns a one-cycle acknowledge to the winning port, and aborts any transfer stalled beyond a bounded number of cycles, flagging a sticky error.

---
 rtl/mips_cpu_bus_arbiter_if.sv | 35 +++
 rtl/mips_cpu_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Requester and Avalon-MM signals of the mips_cpu_bus arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mips_cpu_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
        output i_ack, i_rdata, d_ack, d_rdata, address, write, read, writedata,
        output byteenable, bus_error
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
        input  i_ack, i_rdata, d_ack, d_rdata, address, write, read, writedata,
        input  byteenable, bus_error
    );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between fetch and data ports,
// with registered outputs and a bounded-stall abort that sets a sticky error.
module mips_cpu_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_cpu_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t             state_q, state_d;
    logic [31:0]        address_q, address_d;
    logic [31:0]        writedata_q, writedata_d;
    logic [3:0]         byteenable_q, byteenable_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               bus_error_q, bus_error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    // last_grant also identifies the port owning the current transfer
    logic               last_grant_q, last_grant_d;

    // Next-state and next-output computation for the transfer FSM
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        read_d       = read_q;
        write_d      = write_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        bus_error_d  = bus_error_q;
        stall_cnt_d  = stall_cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req && (!bus.d_req || (last_grant_q == GNT_D))) begin
                    address_d    = {bus.i_addr[31:2], 2'b00};
                    byteenable_d = 4'b1111;
                    writedata_d  = 32'h0000_0000;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    last_grant_d = GNT_I;
                    stall_cnt_d  = {CNT_W{1'b0}};
                    state_d      = S_BUS;
                end else if (bus.d_req) begin
                    address_d    = {bus.d_addr[31:2], 2'b00};
                    byteenable_d = bus.d_be;
                    writedata_d  = bus.d_wdata;
                    read_d       = !bus.d_we;
                    write_d      = bus.d_we;
                    last_grant_d = GNT_D;
                    stall_cnt_d  = {CNT_W{1'b0}};
                    state_d      = S_BUS;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_BUS: begin
                if (!bus.waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = S_RESP;
                    if (last_grant_q == GNT_I) begin
                        i_rdata_d = bus.readdata;
                        i_ack_d   = 1'b1;
                    end else begin
                        if (!write_q) begin
                            d_rdata_d = bus.readdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                        d_ack_d = 1'b1;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    if (stall_cnt_d == CNT_W'(MAX_WAIT)) begin
                        read_d      = 1'b0;
                        write_d     = 1'b0;
                        bus_error_d = 1'b1;
                        state_d     = S_RESP;
                        if (last_grant_q == GNT_I) begin
                            i_rdata_d = 32'h0000_0000;
                            i_ack_d   = 1'b1;
                        end else begin
                            d_rdata_d = 32'h0000_0000;
                            d_ack_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset drops strobes at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            address_q    <= 32'h0000_0000;
            writedata_q  <= 32'h0000_0000;
            byteenable_q <= 4'b0000;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= 32'h0000_0000;
            d_rdata_q    <= 32'h0000_0000;
            bus_error_q  <= 1'b0;
            stall_cnt_q  <= {CNT_W{1'b0}};
            last_grant_q <= GNT_D;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_error_q  <= bus_error_d;
            stall_cnt_q  <= stall_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.i_ack      = i_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.bus_error  = bus_error_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter built with MAX_WAIT=4.
module tb_mips_cpu_bus_arbiter;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    mips_cpu_bus_arbiter_if bif ();

    mips_cpu_bus_arbiter #(.MAX_WAIT(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp_i [4];
        logic [31:0] rd_val [4];
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        bif.i_req = 1'b0;        bif.i_addr = 32'h0;
        bif.d_req = 1'b0;        bif.d_we = 1'b0;
        bif.d_addr = 32'h0;      bif.d_wdata = 32'h0;
        bif.d_be = 4'h0;         bif.waitrequest = 1'b0;
        bif.readdata = 32'h0;

        // reset state
        #12;
        chk("rst_read", bif.read, 1'b0);
        chk("rst_write", bif.write, 1'b0);
        chk("rst_addr", bif.address, 32'h0);
        chk("rst_be", bif.byteenable, 4'h0);
        chk("rst_acks", {bif.i_ack, bif.d_ack}, 2'b00);
        chk("rst_err", bif.bus_error, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // fetch, no stall
        bif.i_req = 1'b1; bif.i_addr = 32'hBFC0_0000;
        bif.waitrequest = 1'b0; bif.readdata = 32'h8C03_0045;
        step();
        chk("f_read", bif.read, 1'b1);
        chk("f_write", bif.write, 1'b0);
        chk("f_addr", bif.address, 32'hBFC0_0000);
        chk("f_be", bif.byteenable, 4'hF);
        chk("f_ack_early", bif.i_ack, 1'b0);
        step();
        chk("f_ack", bif.i_ack, 1'b1);
        chk("f_rdata", bif.i_rdata, 32'h8C03_0045);
        chk("f_read_drop", bif.read, 1'b0);
        bif.i_req = 1'b0;
        step();
        chk("f_ack_once", bif.i_ack, 1'b0);

        // load with three stall cycles
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h0000_0045;
        bif.d_be = 4'hF; bif.waitrequest = 1'b1; bif.readdata = 32'h1111_1111;
        step();
        chk("l_addr", bif.address, 32'h0000_0044);
        for (int k = 0; k < 4; k++) begin
            chk("l_read_held", bif.read, 1'b1);
            chk("l_no_ack", bif.d_ack, 1'b0);
            if (k == 3) begin
                bif.waitrequest = 1'b0;
                bif.readdata = 32'hEC65_21AE;
            end
            step();
        end
        chk("l_ack", bif.d_ack, 1'b1);
        chk("l_rdata", bif.d_rdata, 32'hEC65_21AE);
        chk("l_read_drop", bif.read, 1'b0);
        bif.d_req = 1'b0;
        step();
        chk("l_ack_once", bif.d_ack, 1'b0);

        // store: d_rdata must keep the previous load value
        bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 32'h0000_1000;
        bif.d_wdata = 32'hDEAD_BEEF; bif.d_be = 4'b0011; bif.readdata = 32'h1234_5678;
        step();
        chk("s_write", bif.write, 1'b1);
        chk("s_read", bif.read, 1'b0);
        chk("s_wdata", bif.writedata, 32'hDEAD_BEEF);
        chk("s_be", bif.byteenable, 4'b0011);
        chk("s_addr", bif.address, 32'h0000_1000);
        step();
        chk("s_ack", bif.d_ack, 1'b1);
        chk("s_rdata_kept", bif.d_rdata, 32'hEC65_21AE);
        chk("s_write_drop", bif.write, 1'b0);
        bif.d_req = 1'b0; bif.d_we = 1'b0;
        step();

        // round robin with both ports requesting; last grant was data
        exp_i[0] = 1'b1; exp_i[1] = 1'b0; exp_i[2] = 1'b1; exp_i[3] = 1'b0;
        rd_val[0] = 32'hA000_0001; rd_val[1] = 32'hA000_0002;
        rd_val[2] = 32'hA000_0003; rd_val[3] = 32'hA000_0004;
        bif.i_req = 1'b1; bif.i_addr = 32'h0000_0100;
        bif.d_req = 1'b1; bif.d_addr = 32'h0000_0200; bif.d_be = 4'hF;
        for (int t = 0; t < 4; t++) begin
            bif.readdata = rd_val[t];
            step();
            chk("rr_addr", bif.address, exp_i[t] ? 32'h0000_0100 : 32'h0000_0200);
            step();
            chk("rr_i_ack", bif.i_ack, exp_i[t]);
            chk("rr_d_ack", bif.d_ack, !exp_i[t]);
            if (exp_i[t]) chk("rr_i_rdata", bif.i_rdata, rd_val[t]);
            else          chk("rr_d_rdata", bif.d_rdata, rd_val[t]);
            step();
            chk("rr_ack_clear", {bif.i_ack, bif.d_ack}, 2'b00);
        end
        bif.i_req = 1'b0; bif.d_req = 1'b0;

        // stall timeout after MAX_WAIT=4 cycles
        bif.i_req = 1'b1; bif.i_addr = 32'h0000_0300; bif.waitrequest = 1'b1;
        bif.readdata = 32'h5555_5555;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("to_read_held", bif.read, 1'b1);
            chk("to_no_ack", bif.i_ack, 1'b0);
            step();
        end
        chk("to_read_drop", bif.read, 1'b0);
        chk("to_ack", bif.i_ack, 1'b1);
        chk("to_rdata_zero", bif.i_rdata, 32'h0);
        chk("to_err", bif.bus_error, 1'b1);
        bif.i_req = 1'b0; bif.waitrequest = 1'b0;
        step();
        chk("to_ack_once", bif.i_ack, 1'b0);
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h0000_0400;
        bif.readdata = 32'hCAFE_F00D;
        step();
        step();
        chk("post_err_ack", bif.d_ack, 1'b1);
        chk("post_err_rdata", bif.d_rdata, 32'hCAFE_F00D);
        chk("err_sticky", bif.bus_error, 1'b1);
        bif.d_req = 1'b0;
        step();

        // asynchronous reset while a load is stalled in BUS
        bif.d_req = 1'b1; bif.d_addr = 32'h0000_0600; bif.waitrequest = 1'b1;
        step();
        chk("ar_read_before", bif.read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_read", bif.read, 1'b0);
        chk("ar_write", bif.write, 1'b0);
        chk("ar_acks", {bif.i_ack, bif.d_ack}, 2'b00);
        chk("ar_err", bif.bus_error, 1'b0);
        bif.i_req = 1'b1; bif.i_addr = 32'h0000_0500;
        bif.waitrequest = 1'b0; bif.readdata = 32'h7777_0001;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("ar_first_grant", bif.address, 32'h0000_0500);
        chk("ar_grant_read", bif.read, 1'b1);
        step();
        chk("ar_i_ack", bif.i_ack, 1'b1);
        chk("ar_d_ack", bif.d_ack, 1'b0);
        bif.i_req = 1'b0; bif.d_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
